cnt_sched: RTL

Round-robin scheduler that shares a single CNT_W-bit up-counter between NREQ requesters in the transceiver counter subsystem. Each requester asks for a count window of its own length. The block grants the counter to one requester at a time, runs it from 0 to the requested terminal value, and pulses a per-requester done. It replaces ad-hoc per-channel counters where channels need timed windows that never overlap.

---
 rtl/cnt_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cnt_sched.sv
// cnt_sched: shares one CNT_W-bit up-counter between NREQ requesters.
// A requester is granted the counter, which then runs from 0 to that
// requester's latched terminal value. On completion the owner receives a
// one-cycle done pulse. Every output is driven straight from a register.
//
// Optional feature: define CNT_SCHED_PRIO_EN for fixed-priority arbitration.
// In that mode the lowest set request index always wins and the round-robin
// pointer is held at 0. By default, arbitration is round-robin.
module cnt_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   req_len,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [CNT_W-1:0]        cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0]   r_len,   w_len_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [NREQ-1:0]    r_done,  w_done_nxt;
  logic               r_busy,  w_busy_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;

  logic [PTR_W-1:0]   w_base;
  logic [PTR_W-1:0]   w_pick;
  logic [CNT_W-1:0]   w_pick_len;

  // First set bit of v, searching upward from ptr and wrapping modulo NREQ.
  function automatic logic [PTR_W-1:0] f_pick(input logic [NREQ-1:0] v,
                                              input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && v[idx]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [NREQ-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // The requester after owner, wrapping modulo NREQ. In fixed-priority mode
  // the pointer stays at 0.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] owner);
`ifdef CNT_SCHED_PRIO_EN
    return (owner == owner) ? '0 : '0;
`else
    if (owner == PTR_W'(NREQ - 1)) begin
      return '0;
    end else begin
      return owner + PTR_W'(1);
    end
`endif
  endfunction

`ifdef CNT_SCHED_PRIO_EN
  assign w_base = '0;
`else
  assign w_base = r_rr_ptr;
`endif

  assign w_pick     = f_pick(req, w_base);
  assign w_pick_len = req_len[int'(w_pick)*CNT_W +: CNT_W];

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign cnt   = r_cnt;

  // Next-state and next-output logic for the IDLE/RUN window scheduler.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_busy_nxt   = r_busy;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_pick;
          w_len_nxt   = w_pick_len;
          w_cnt_nxt   = '0;
          w_grant_nxt = f_onehot(w_pick);
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = '0;
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        if (!req[r_owner]) begin
          // An abort wins over completion and produces no done pulse.
          w_grant_nxt  = '0;
          w_busy_nxt   = 1'b0;
          w_cnt_nxt    = '0;
          w_rr_ptr_nxt = f_next_ptr(r_owner);
          w_state_nxt  = S_IDLE;
        end else if (r_cnt == r_len) begin
          w_done_nxt   = f_onehot(r_owner);
          w_grant_nxt  = '0;
          w_busy_nxt   = 1'b0;
          w_cnt_nxt    = '0;
          w_rr_ptr_nxt = f_next_ptr(r_owner);
          w_state_nxt  = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = '0;
        w_len_nxt    = '0;
        w_grant_nxt  = '0;
        w_busy_nxt   = 1'b0;
        w_rr_ptr_nxt = '0;
        w_owner_nxt  = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

endmodule
